// File: rtl/zpulse_pkg.sv
// ============================================================================
// Module      : zpulse_pkg
// Description : Shared constants, types and helpers for the pulse-count frame
//               transmitter (header bytes, byte indices, FSM encoding, queued
//               sample type, CRC-8 byte update).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package zpulse_pkg;

  localparam logic [7:0] c_HDR0 = 8'hA5;
  localparam logic [7:0] c_HDR1 = 8'h5A;

  localparam int unsigned c_FRAME_LEN = 8;

  // Byte positions inside a frame
  localparam logic [2:0] c_IDX_HDR0 = 3'd0;
  localparam logic [2:0] c_IDX_HDR1 = 3'd1;
  localparam logic [2:0] c_IDX_SEQ  = 3'd2;
  localparam logic [2:0] c_IDX_CNT3 = 3'd3;
  localparam logic [2:0] c_IDX_CNT2 = 3'd4;
  localparam logic [2:0] c_IDX_CNT1 = 3'd5;
  localparam logic [2:0] c_IDX_CNT0 = 3'd6;
  localparam logic [2:0] c_IDX_CHK  = 3'(c_FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_CHKB = 2'd3
  } tx_state_e;

  // One queued sample: sequence number stamped at capture plus the count
  typedef struct packed {
    logic [7:0]  seq;
    logic [31:0] count;
  } sample_t;

  // CRC-8, polynomial 0x07, MSB-first, one byte folded into the running value
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/zpulse_sample_fifo.sv
// ============================================================================
// Module      : zpulse_sample_fifo
// Description : Synchronous FIFO of sample_t entries with show-ahead read.
//               A push while full is accepted when a pop happens in the same
//               cycle (the freed slot is the one written).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zpulse_sample_fifo
  import zpulse_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  sample_t wdata_i,
  input  logic    pop_i,
  output sample_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);

  sample_t        mem_q [DEPTH];
  logic    [AW:0] wptr_q;
  logic    [AW:0] rptr_q;
  logic           w_push_ok;
  logic           w_pop_ok;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign w_pop_ok  = pop_i & ~empty_o;
  assign w_push_ok = push_i & (~full_o | w_pop_ok);
  assign rdata_o   = mem_q[rptr_q[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_push_ok) wptr_q <= wptr_q + 1'b1;
      if (w_pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers qualify them
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/zpulse_frame_tx.sv
// ============================================================================
// Module      : zpulse_frame_tx
// Description : Captures 1 ms pulse-count samples, queues them and sends each
//               as an 8-byte frame (HDR0 HDR1 SEQ CNT[31:0] CHK) on a
//               byte-wide valid/ready stream. Counts samples lost to overflow.
//               Build option: define ZPULSE_FRAME_CRC8_EN to make CHK a CRC-8
//               (poly 0x07) instead of the 8-bit additive sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zpulse_frame_tx
  import zpulse_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HDR0       = c_HDR0,
  parameter logic [7:0] HDR1       = c_HDR1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] iCount,
  input  logic        iUpdate,
  output logic [7:0]  oData,
  output logic        oValid,
  input  logic        iReady,
  output logic        oBusy,
  output logic [15:0] oDropCnt
);

  tx_state_e   state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  seq_q;
  logic [15:0] drop_q;
  sample_t     frame_q;

  sample_t     w_head;
  sample_t     w_wdata;
  logic        w_full;
  logic        w_empty;
  logic        w_cap;
  logic        w_pop;
  logic        w_drop;
  logic [7:0]  w_send_byte;

  assign w_cap    = iUpdate & en;
  assign w_drop   = w_cap & w_full & ~w_pop;
  assign w_wdata  = '{seq: seq_q, count: iCount};
  assign oBusy    = (state_q != ST_IDLE) | ~w_empty;
  assign oDropCnt = drop_q;

  zpulse_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_cap),
    .wdata_i (w_wdata),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Sequence stamps every enabled strobe; drops saturate at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q  <= 8'd0;
      drop_q <= 16'd0;
    end else begin
      if (w_cap) seq_q <= seq_q + 8'd1;
      if (w_drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // The popped head is held for the whole frame; the FIFO slot is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_q <= '0;
    else if (w_pop) frame_q <= w_head;
  end

  // FSM, byte index and checksum accumulator registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      acc_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Byte selected by the current index while in SEND
  always_comb begin
    w_send_byte = acc_q;
    case (idx_q)
      c_IDX_HDR0: w_send_byte = HDR0;
      c_IDX_HDR1: w_send_byte = HDR1;
      c_IDX_SEQ:  w_send_byte = frame_q.seq;
      c_IDX_CNT3: w_send_byte = frame_q.count[31:24];
      c_IDX_CNT2: w_send_byte = frame_q.count[23:16];
      c_IDX_CNT1: w_send_byte = frame_q.count[15:8];
      c_IDX_CNT0: w_send_byte = frame_q.count[7:0];
      c_IDX_CHK:  w_send_byte = acc_q;
      default:    w_send_byte = acc_q;
    endcase
  end

  // Next state, FIFO pop and stream outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    w_pop   = 1'b0;
    oValid  = 1'b0;
    oData   = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        idx_d   = c_IDX_HDR0;
        acc_d   = 8'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        oValid = 1'b1;
        oData  = w_send_byte;
        if (iReady) begin
          if (idx_q >= c_IDX_SEQ) begin
`ifdef ZPULSE_FRAME_CRC8_EN
            acc_d = crc8_update(acc_q, w_send_byte);
`else
            acc_d = acc_q + w_send_byte;
`endif
          end
          if (idx_q == c_IDX_CNT0) begin
            idx_d   = c_IDX_CHK;
            state_d = ST_CHKB;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_CHKB: begin
        oValid = 1'b1;
        oData  = acc_q;
        if (iReady) begin
          if (!w_empty) begin
            w_pop   = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_zpulse_frame_tx.sv
// ============================================================================
// Module      : tb_zpulse_frame_tx
// Description : Scoreboard bench for zpulse_frame_tx. Stimulus pushes expected
//               frame bytes; an independent monitor pops and compares every
//               accepted byte and watches the hold/no-gap stream rules.
//               Honours ZPULSE_FRAME_CRC8_EN for the expected CHK byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_zpulse_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] iCount;
  logic        iUpdate;
  logic [7:0]  oData;
  logic        oValid;
  logic        iReady;
  logic        oBusy;
  logic [15:0] oDropCnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  seq_m;
  int          ready_mode;

  zpulse_frame_tx #(
    .FIFO_DEPTH (4),
    .HDR0       (8'hA5),
    .HDR1       (8'h5A)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .iCount   (iCount),
    .iUpdate  (iUpdate),
    .oData    (oData),
    .oValid   (oValid),
    .iReady   (iReady),
    .oBusy    (oBusy),
    .oDropCnt (oDropCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference check byte: bit-serial long division for CRC, plain sum otherwise
  function automatic logic [7:0] chk_of(input logic [7:0] s, input logic [31:0] c);
    logic [39:0] msg;
    logic [7:0]  r;
    logic        fb;
    msg = {s, c};
    r   = 8'h00;
`ifdef ZPULSE_FRAME_CRC8_EN
    for (int i = 39; i >= 0; i--) begin
      fb = r[7] ^ msg[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
`else
    fb = 1'b0;
    r  = msg[39:32] + msg[31:24] + msg[23:16] + msg[15:8] + msg[7:0];
`endif
    return r;
  endfunction

  task automatic push_frame(input logic [7:0] s, input logic [31:0] c);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(s);
    exp_q.push_back(c[31:24]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(chk_of(s, c));
  endtask

  // One-cycle strobe, called #1 after a rising edge
  task automatic strobe_raw(input logic [31:0] c);
    iCount  = c;
    iUpdate = 1'b1;
    @(posedge clk); #1;
    iUpdate = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] c, input bit stored);
    if (en && stored) push_frame(seq_m, c);
    if (en) seq_m = seq_m + 8'd1;
    strobe_raw(c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && !oBusy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    seq_m = 8'd0;
    idle(2);
    rst = 1'b0;
  endtask

  // Downstream ready driver: 0 low, 1 high, 2 random
  initial begin
    iReady = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       iReady = 1'b0;
        1:       iReady = 1'b1;
        default: iReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare accepted bytes, enforce hold under back-pressure, no gaps
  initial begin
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    logic [7:0] e;
    int         pos;
    pv = 1'b0; pr = 1'b0; pd = 8'h00; pos = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; pos = 0;
      end else begin
        if (pv && !pr) begin
          check("hold_valid", {31'd0, oValid}, 32'd1);
          check("hold_data", {24'd0, oData}, {24'd0, pd});
        end else if (pos != 0) begin
          check("no_gap", {31'd0, oValid}, 32'd1);
        end
        if (oValid && iReady) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got %02h expected no byte", oData);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", {24'd0, oData}, {24'd0, e});
          end
          pos = (pos + 1) % 8;
        end
        pv = oValid; pr = iReady; pd = oData;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         first;
    logic [7:0] c;
    rst = 1'b1; en = 1'b1; iUpdate = 1'b0; iCount = 32'd0;
    ready_mode = 1; seq_m = 8'd0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    check("rst_valid", {31'd0, oValid}, 32'd0);
    check("rst_data", {24'd0, oData}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    check("rst_drop", {16'd0, oDropCnt}, 32'd0);

    // Single sample, hand-written frame, first byte 3 cycles after strobe
`ifdef ZPULSE_FRAME_CRC8_EN
    c = chk_of(8'h00, 32'h12345678);
`else
    c = 8'h14;
`endif
    foreach (c_bytes1[i]) exp_q.push_back(c_bytes1[i]);
    exp_q.push_back(c);
    seq_m   = 8'd1;
    iCount  = 32'h12345678;
    iUpdate = 1'b1;
    first   = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 1) iUpdate = 1'b0;
      if (oValid && first == 0) first = k;
    end
    check("latency", first, 32'd3);
    drain("drain_single", 100);

    // Back-pressure: random ready, stream must hold and not gap
    ready_mode = 2;
    strobe(32'h12345678, 1'b1);
    drain("drain_bp", 400);
    ready_mode = 1;
    idle(2);

    // Overflow: the frame engine pops the first sample, so four more fill the
    // FIFO and the sixth is dropped while the stream is stalled
    do_reset();
    ready_mode = 0;
    idle(2);
    for (int i = 1; i <= 6; i++) begin
      strobe(32'(i), i <= 5);
      idle(2);
    end
    check("ovf_drop", {16'd0, oDropCnt}, 32'd1);
    check("ovf_busy", {31'd0, oBusy}, 32'd1);
    ready_mode = 1;
    drain("drain_ovf", 300);
    strobe(32'h00000007, 1'b1);
    drain("drain_ovf_next", 100);
    check("ovf_drop_hold", {16'd0, oDropCnt}, 32'd1);

    // Sequence wrap over 257 draining strobes
    do_reset();
    for (int i = 0; i < 257; i++) begin
      strobe(32'(i * 7 + 3), 1'b1);
      idle(11);
    end
    drain("drain_wrap", 100);
    check("wrap_drop", {16'd0, oDropCnt}, 32'd0);

    // Reset after the third accepted byte
    strobe(32'hCAFEF00D, 1'b1);
    first = 0;
    for (int k = 0; k < 20 && !oValid; k++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, oValid}, 32'd0);
    check("midrst_drop", {16'd0, oDropCnt}, 32'd0);
    exp_q.delete();
    seq_m = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
`ifdef ZPULSE_FRAME_CRC8_EN
    c = chk_of(8'h00, 32'h0000000A);
`else
    c = 8'h0A;
`endif
    foreach (c_bytes2[i]) exp_q.push_back(c_bytes2[i]);
    exp_q.push_back(c);
    seq_m = 8'd1;
    strobe_raw(32'h0000000A);
    drain("drain_after_rst", 100);

    // Capture disabled: no frame, sequence unchanged
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(32'h00000063, 1'b1);
      idle(3);
    end
    check("en_low_busy", {31'd0, oBusy}, 32'd0);
    check("en_low_valid", {31'd0, oValid}, 32'd0);
    en = 1'b1;
    strobe(32'hDEADBEEF, 1'b1);
    drain("drain_en", 100);
    check("final_drop", {16'd0, oDropCnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hand-computed frame prefixes (CHK appended separately)
  logic [7:0] c_bytes1 [7] = '{8'hA5, 8'h5A, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
  logic [7:0] c_bytes2 [7] = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A};

endmodule

`default_nettype wire
